// File: rtl/ks_pkg.sv
// Shared types for the Kogge-Stone sum stage: the packed result word layout
// and the state encoding of the two-entry skid buffer.
package ks_pkg;

  localparam int KS_WIDTH = 16;
  localparam int KS_TAG_W = 4;

  typedef struct packed {
    logic [KS_TAG_W-1:0] tag;
    logic                neg;
    logic                zero;
    logic                ovf;
    logic                cout;
    logic [KS_WIDTH-1:0] sum;
  } ks_result_t;

  localparam int KS_RES_W = $bits(ks_result_t);

  typedef enum logic [1:0] {
    STATE_EMPTY = 2'd0,
    STATE_ONE   = 2'd1,
    STATE_FULL  = 2'd2
  } ks_state_e;

endpackage

// File: rtl/ks_skid_buf.sv
// Two-entry valid/ready skid buffer. o_ready is a flop so the upstream ready
// path is cut from the downstream one; order is preserved.
module ks_skid_buf
  import ks_pkg::*;
#(
  parameter int DATA_W = KS_RES_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  ks_state_e         r_state;
  ks_state_e         w_state_nxt;
  logic              r_ready;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  assign o_ready    = r_ready;
  assign o_valid    = (r_state != STATE_EMPTY);
  assign o_data     = r_main;
  assign w_in_xfer  = i_valid & r_ready;
  assign w_out_xfer = o_valid & i_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      STATE_EMPTY: begin
        if (w_in_xfer) begin
          w_load_main_in = 1'b1;
          w_state_nxt    = STATE_ONE;
        end
      end
      STATE_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_in_xfer) begin
          w_load_skid = 1'b1;
          w_state_nxt = STATE_FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = STATE_EMPTY;
        end
      end
      STATE_FULL: begin
        // ready is low here, so only the drain side can move
        if (w_out_xfer) begin
          w_load_main_skid = 1'b1;
          w_state_nxt      = STATE_ONE;
        end
      end
      default: w_state_nxt = STATE_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STATE_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != STATE_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= i_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

endmodule

// File: rtl/ks_sum_stage.sv
// Sum/flag stage after the Kogge-Stone prefix network: forms sum and status
// flags, buffers them through a skid buffer and keeps saturating statistics.
module ks_sum_stage
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH,
  parameter int TAG_W = KS_TAG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   g_prefix,
  input  logic [WIDTH:0]   p_bit,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] out_tag,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int              DATA_W  = TAG_W + 4 + WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;
  logic              w_ovf;
  logic [DATA_W-1:0] w_res_in;
  logic [DATA_W-1:0] w_res_out;
  logic              w_out_xfer;
  logic              w_unused_p0;
  logic [CNT_W-1:0]  r_op_count;
  logic [CNT_W-1:0]  r_ovf_count;

  // p_bit[0] sits in the carry-in slot and carries no propagate information
  assign w_unused_p0 = p_bit[0];

  assign w_sum    = p_bit[WIDTH:1] ^ g_prefix[WIDTH-1:0];
  assign w_cout   = g_prefix[WIDTH];
  assign w_ovf    = g_prefix[WIDTH] ^ g_prefix[WIDTH-1];
  assign w_res_in = {in_tag, w_sum[WIDTH-1], (w_sum == '0), w_ovf, w_cout, w_sum};

  ks_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_res_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_res_out)
  );

  assign {out_tag, neg, zero, ovf, cout, sum} = w_res_out;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count  <= '0;
      r_ovf_count <= '0;
    end else if (stat_clr) begin
      r_op_count  <= '0;
      r_ovf_count <= '0;
    end else if (w_out_xfer) begin
      if (r_op_count != CNT_MAX) begin
        r_op_count <= r_op_count + 1'b1;
      end
      if (ovf && (r_ovf_count != CNT_MAX)) begin
        r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end

  assign op_count  = r_op_count;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_ks_sum_stage.sv
// Randomised self-checking bench for ks_sum_stage: operands come from a plain
// a+b+cin model, results are tracked with an occupancy-based scoreboard.
module tb_ks_sum_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [16:0] g_prefix;
  logic [16:0] p_bit;
  logic [3:0]  in_tag;
  logic        out_ready;
  logic        stat_clr;

  logic        in_ready,  in_ready4;
  logic        out_valid, out_valid4;
  logic [15:0] sum,       sum4;
  logic        cout,      cout4;
  logic        ovf,       ovf4;
  logic        zero,      zero4;
  logic        neg,       neg4;
  logic [3:0]  out_tag,   out_tag4;
  logic [15:0] op_count,  ovf_count;
  logic [3:0]  op_count4, ovf_count4;

  ks_sum_stage #(.WIDTH(16), .TAG_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .g_prefix(g_prefix), .p_bit(p_bit), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .zero(zero), .neg(neg), .out_tag(out_tag),
    .stat_clr(stat_clr), .op_count(op_count), .ovf_count(ovf_count)
  );

  ks_sum_stage #(.WIDTH(16), .TAG_W(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .g_prefix(g_prefix), .p_bit(p_bit), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4), .cout(cout4),
    .ovf(ovf4), .zero(zero4), .neg(neg4), .out_tag(out_tag4),
    .stat_clr(stat_clr), .op_count(op_count4), .ovf_count(ovf_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  logic [23:0] exp_q[$];
  logic [3:0]  emitted[$];
  int          m_op16, m_ovf16, m_op4, m_ovf4;
  bit          acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {tag, neg, zero, ovf, cout, sum} straight from integer addition
  function automatic logic [23:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic [3:0] tag);
    logic [16:0] s;
    logic        v;
    s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    v = (a[15] == b[15]) && (s[15] != a[15]);
    return {tag, s[15], (s[15:0] == 16'd0), v, s[16], s[15:0]};
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    m_op16 = 0; m_ovf16 = 0; m_op4 = 0; m_ovf4 = 0;
  endtask

  task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [3:0] tag, input bit ordy,
                       input bit clr, output bit accepted);
    logic [16:0] carries;
    bit          in_x, out_x;
    @(negedge clk);
    chk("in_ready",   32'(in_ready),   32'(exp_q.size() < 2));
    chk("out_valid",  32'(out_valid),  32'(exp_q.size() > 0));
    chk("op_count",   32'(op_count),   m_op16);
    chk("ovf_count",  32'(ovf_count),  m_ovf16);
    chk("op_count4",  32'(op_count4),  m_op4);
    chk("ovf_count4", 32'(ovf_count4), m_ovf4);
    if (exp_q.size() > 0) begin
      chk("result",  32'({out_tag, neg, zero, ovf, cout, sum}),        32'(exp_q[0]));
      chk("result4", 32'({out_tag4, neg4, zero4, ovf4, cout4, sum4}),  32'(exp_q[0]));
    end
    // carry into bit i is what remains of the sum bit once a^b is removed
    carries   = ({1'b0, a} + {1'b0, b} + {16'd0, cin}) ^ {1'b0, a} ^ {1'b0, b};
    in_valid  = v;
    g_prefix  = carries;
    p_bit     = {a ^ b, 1'($urandom_range(0, 1))};
    in_tag    = tag;
    out_ready = ordy;
    stat_clr  = clr;
    in_x  = v && (exp_q.size() < 2);
    out_x = ordy && (exp_q.size() > 0);
    if (out_x) begin
      emitted.push_back(exp_q[0][23:20]);
      m_op16 = sat_inc(m_op16, 65535);
      m_op4  = sat_inc(m_op4, 15);
      if (exp_q[0][17]) begin
        m_ovf16 = sat_inc(m_ovf16, 65535);
        m_ovf4  = sat_inc(m_ovf4, 15);
      end
      void'(exp_q.pop_front());
    end
    if (clr) begin
      m_op16 = 0; m_ovf16 = 0; m_op4 = 0; m_ovf4 = 0;
    end
    if (in_x) exp_q.push_back(model(a, b, cin, tag));
    accepted = in_x;
  endtask

  task automatic idle(input bit ordy);
    bit dummy;
    drive(1'b0, 16'd0, 16'd0, 1'b0, 4'd0, ordy, 1'b0, dummy);
  endtask

  task automatic rand_op(input bit ordy, output bit accepted);
    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), ordy, 1'b0, accepted);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clear_model();
    rst_n = 1'b0; in_valid = 1'b0; g_prefix = '0; p_bit = '0;
    in_tag = '0; out_ready = 1'b0; stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_word",      32'({out_tag, neg, zero, ovf, cout, sum}), 0);
    chk("rst_counts",    32'({op_count, ovf_count}), 0);
    rst_n = 1'b1;

    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 4'd1, 1'b1, 1'b0, acc);
    idle(1'b1);
    chk("ovf_case", 32'({neg, zero, ovf, cout, sum}), 32'({1'b1, 1'b0, 1'b1, 1'b0, 16'h8000}));
    idle(1'b1);
    chk("ovf_case_op",  32'(op_count),  1);
    chk("ovf_case_ovf", 32'(ovf_count), 1);

    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 4'd2, 1'b1, 1'b0, acc);
    idle(1'b1);
    chk("wrap_case", 32'({neg, zero, ovf, cout, sum}), 32'({1'b0, 1'b1, 1'b0, 1'b1, 16'h0000}));
    drive(1'b1, 16'h1234, 16'h0000, 1'b1, 4'd3, 1'b1, 1'b0, acc);
    idle(1'b1);
    chk("cin_case", 32'(sum), 32'h1235);

    drive(1'b0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 20; i++)
      drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 4'(i), 1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b1);
    chk("sat_op4",  32'(op_count4),  15);
    chk("sat_ovf4", 32'(ovf_count4), 15);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 4'd9, 1'b1, 1'b0, acc);
    drive(1'b0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1, 1'b1, acc);
    idle(1'b1);
    chk("clr_op4",  32'(op_count4),  0);
    chk("clr_ovf4", 32'(ovf_count4), 0);

    for (int i = 0; i < 100; i++) begin
      rand_op(1'b1, acc);
      chk("thru_accept", 32'(acc), 1);
    end
    idle(1'b1);
    idle(1'b1);
    chk("thru_op_count", 32'(op_count), 100);

    emitted.delete();
    drive(1'b1, 16'h0011, 16'h0022, 1'b0, 4'd1, 1'b0, 1'b0, acc);
    drive(1'b1, 16'h0033, 16'h0044, 1'b0, 4'd2, 1'b0, 1'b0, acc);
    drive(1'b1, 16'h0055, 16'h0066, 1'b0, 4'd3, 1'b0, 1'b0, acc);
    chk("bp_tag3_held", 32'(acc), 0);
    drive(1'b1, 16'h0055, 16'h0066, 1'b0, 4'd3, 1'b0, 1'b0, acc);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_tag",  32'(out_tag),  1);
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++)
      drive(1'b1, 16'h0055, 16'h0066, 1'b0, 4'd3, 1'b1, 1'b0, acc);
    chk("bp_tag3_taken", 32'(acc), 1);
    repeat (3) idle(1'b1);
    chk("bp_emitted_n", emitted.size(), 3);
    if (emitted.size() == 3)
      chk("bp_order", 32'({emitted[0], emitted[1], emitted[2]}), 32'h123);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) rand_op(1'($urandom_range(0, 1)), acc);
      else idle(1'($urandom_range(0, 1)));
    end

    drive(1'b1, 16'h0100, 16'h0200, 1'b0, 4'd7, 1'b0, 1'b0, acc);
    drive(1'b1, 16'h0300, 16'h0400, 1'b0, 4'd8, 1'b0, 1'b0, acc);
    drive(1'b1, 16'h0300, 16'h0400, 1'b0, 4'd8, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready",  32'(in_ready),  1);
    chk("arst_word",      32'({out_tag, neg, zero, ovf, cout, sum}), 0);
    chk("arst_counts",    32'({op_count, ovf_count, op_count4, ovf_count4}), 0);
    clear_model();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h8000, 16'h8000, 1'b0, 4'd5, 1'b1, 1'b0, acc);
    idle(1'b1);
    chk("post_rst_word", 32'({out_tag, neg, zero, ovf, cout, sum}),
        32'({4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000}));
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ks_sum_stage.md
Name: ks_sum_stage

Overview:
Registered sum/flag stage directly downstream of the Kogge-Stone group-PG prefix network. It consumes the prefix carries Gi[WIDTH:0] and the bitwise propagate vector P[WIDTH:0], and forms sum, carry-out and status flags. Results are presented on a valid/ready interface through a 2-entry skid buffer, so the combinational prefix tree never sits on the downstream ready path. It also keeps saturating operation and overflow counters for adder characterisation runs.

Parameters:
WIDTH, 16, operand width; matches the prefix network's WIDTH (vectors are WIDTH+1 bits, bit 0 = carry-in slot)
TAG_W, 4, width of the sideband tag carried with each operation
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream holds valid g_prefix/p_bit/in_tag
in_ready  output  1  stage can accept; registered
g_prefix  input  WIDTH+1  Gi from prefix network; Gi[i] = carry into bit i, Gi[WIDTH] = carry-out
p_bit  input  WIDTH+1  bitwise propagate; p_bit[i+1] = a[i]^b[i]; p_bit[0] is don't-care
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
sum  output  WIDTH  sum[i] = p_bit[i+1] ^ g_prefix[i]
cout  output  1  g_prefix[WIDTH]
ovf  output  1  signed overflow = g_prefix[WIDTH] ^ g_prefix[WIDTH-1]
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]
out_tag  output  TAG_W  tag of presented result
stat_clr  input  1  synchronous clear of both counters
op_count  output  CNT_W  completed output transfers, saturating
ovf_count  output  CNT_W  completed transfers with ovf=1, saturating

Behaviour:
- Reset (async, rst_n low): out_valid=0; in_ready=1; sum, cout, ovf, zero, neg, out_tag=0; skid entry invalid; op_count=ovf_count=0. Reset mid-transfer drops any held entries. Nothing is replayed.
- Result word {tag, neg, zero, ovf, cout, sum} is computed combinationally at the input and registered. Latency is 1 cycle from input acceptance to out_valid when the output register is empty or draining.
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- State is two entries: main (drives outputs) and skid.
  - EMPTY: main invalid. An input transfer loads main and moves to ONE.
  - ONE: main valid, skid invalid.
    - Input and output transfer together: main reloads; stay in ONE.
    - Input only: load skid; go to FULL; in_ready=0 next cycle.
    - Output only: go to EMPTY.
  - FULL: in_ready=0. An output transfer moves skid into main; go to ONE; in_ready=1 next cycle.
- in_ready = !skid_valid, registered. Inputs are never dropped or duplicated.
- Outputs are stable while out_valid & !out_ready.
- Order is preserved (FIFO).
- Counters:
  - Increment on each output transfer. ovf_count increments only when ovf=1 on that transfer.
  - Both saturate at 2^CNT_W-1.
  - stat_clr has priority over increment in the same cycle (result 0).
- p_bit[0] is ignored. g_prefix[0] is the carry-in, so sum[0] = p_bit[1]^cin.

Decomposition:
- Shared package (ks_pkg):
  - result struct {tag, neg, zero, ovf, cout, sum}, parameterised by WIDTH/TAG_W through localparams
  - STATE_EMPTY/ONE/FULL encoding
- One sub-module: ks_skid_buf. Generic 2-entry valid/ready skid buffer on a DATA_W payload, instantiated with the packed result word.
- Flag/sum logic and counters stay in ks_sum_stage.

Test Plan:
(WIDTH=16. Prefix vectors come from a golden a+b+cin model feeding the actual prefix network.)
- a=0x7FFF, b=0x0001, cin=0, out_ready=1 -> next cycle: sum=0x8000, ovf=1, cout=0, neg=1, zero=0; op_count=1, ovf_count=1.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0. Also a=0x1234, b=0x0000, cin=1 -> sum=0x1235.
- Backpressure: out_ready=0, send tags 1, 2, 3 back-to-back -> tag 1 is held on outputs, tag 2 goes into skid, in_ready=0 from the cycle after tag 2 is accepted, and tag 3 is held upstream. Raise out_ready -> tags 1, 2, 3 emerge in order with no loss.
- Throughput: in_valid=out_ready=1 for 100 random operations -> one result per cycle after 1-cycle latency; all match the model; op_count=100.
- Saturation/clear (CNT_W=4): 20 overflowing transfers -> op_count=ovf_count=15. stat_clr asserted together with a transfer -> both counters 0 next cycle.
- Assert rst_n low asynchronously while in FULL -> out_valid=0 and in_ready=1 immediately. Counters and outputs are 0. The first post-reset input yields a correct result 1 cycle later.
